// File: rtl/c_reader_pkg.sv
// Shared types and layout helpers for the C result reader and the accelerator writer.
// lane_index/word_addr describe where C[m][n] sits in the M*N-lane packed SRAM C.
package c_reader_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  function automatic int unsigned lane_index(input int unsigned m, input int unsigned n,
                                             input int unsigned pm, input int unsigned pn);
    return (m % pm) * pn + (n % pn);
  endfunction

  function automatic int unsigned word_addr(input int unsigned m, input int unsigned n,
                                            input int unsigned n_size,
                                            input int unsigned pm, input int unsigned pn);
    return (m / pm) * (n_size / pn) + n / pn;
  endfunction

endpackage

// File: rtl/c_reader_fifo.sv
// Two-entry synchronous FIFO holding unpacked C elements with their last flag.
module c_reader_fifo
  import c_reader_pkg::*;
#(
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_fire, pop_fire;

  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign pop_fire  = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_fire = push_i && (!full_o || pop_fire);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop_fire) begin
      rd_ptr_d = !rd_ptr_q;
    end
    if (push_fire && !pop_fire) begin
      count_d = count_q + 2'd1;
    end else if (!push_fire && pop_fire) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/c_result_reader.sv
// Drains packed SRAM C after a GEMM run and streams C row-major over valid/ready.
// One read per element; the lane is picked from the word one cycle after the address.
module c_result_reader
  import c_reader_pkg::*;
#(
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned M             = 2,
  parameter int unsigned N             = 1,
  parameter int unsigned AddrWidthC    = 9,
  parameter int unsigned SizeAddrWidth = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [SizeAddrWidth-1:0]  M_size_i,
  input  logic [SizeAddrWidth-1:0]  N_size_i,
  output logic [AddrWidthC-1:0]     sram_c_addr_o,
  input  logic [OutDataWidth*M*N-1:0] sram_c_rdata_i,
  output logic [OutDataWidth-1:0]   out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned Lanes = M * N;
  localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;

  state_e                   state_q, state_d;
  logic [SizeAddrWidth-1:0] m_size_q, m_size_d;
  logic [SizeAddrWidth-1:0] n_size_q, n_size_d;
  logic [SizeAddrWidth-1:0] m_cnt_q, m_cnt_d;
  logic [SizeAddrWidth-1:0] n_cnt_q, n_cnt_d;
  logic [AddrWidthC-1:0]    addr_q, addr_d;
  logic [LaneW-1:0]         lane_q, lane_d;
  logic                     last_q, last_d;
  logic                     inflight_q, inflight_d;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]               fifo_count;
  logic [OutDataWidth:0]    fifo_wdata, fifo_rdata;
  logic [OutDataWidth-1:0]  lane_data;
  logic [AddrWidthC-1:0]    issue_addr;
  logic [LaneW-1:0]         issue_lane;
  logic [2:0]               occ;
  logic                     issue, n_wrap, last_elem;

  assign issue_addr = AddrWidthC'(word_addr(32'(m_cnt_q), 32'(n_cnt_q), 32'(n_size_q), M, N));
  assign issue_lane = LaneW'(lane_index(32'(m_cnt_q), 32'(n_cnt_q), M, N));
  assign n_wrap     = (n_cnt_q == n_size_q - SizeAddrWidth'(1));
  assign last_elem  = n_wrap && (m_cnt_q == m_size_q - SizeAddrWidth'(1));

  assign fifo_pop  = !fifo_empty && out_ready_i;
  assign occ       = 3'(fifo_count) + 3'(inflight_q);
  // Credit: FIFO entries plus the read in flight, minus what leaves now, must stay below 2.
  assign issue     = (state_q == StRun) && (occ < 3'd2 + 3'(fifo_pop));

  always_comb begin
    lane_data = '0;
    for (int unsigned u = 0; u < Lanes; u++) begin
      if (lane_q == LaneW'(u)) begin
        lane_data = sram_c_rdata_i[u*OutDataWidth +: OutDataWidth];
      end
    end
  end

  assign fifo_push  = inflight_q;
  assign fifo_wdata = {last_q, lane_data};

  c_reader_fifo #(
    .Width (OutDataWidth + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    m_size_d   = m_size_q;
    n_size_d   = n_size_q;
    m_cnt_d    = m_cnt_q;
    n_cnt_d    = n_cnt_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    last_d     = last_q;
    inflight_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          m_size_d = M_size_i;
          n_size_d = N_size_i;
          m_cnt_d  = '0;
          n_cnt_d  = '0;
          state_d  = (M_size_i == '0 || N_size_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue) begin
          inflight_d = 1'b1;
          addr_d     = issue_addr;
          lane_d     = issue_lane;
          last_d     = last_elem;
          if (n_wrap) begin
            n_cnt_d = '0;
            m_cnt_d = m_cnt_q + SizeAddrWidth'(1);
          end else begin
            n_cnt_d = n_cnt_q + SizeAddrWidth'(1);
          end
          if (last_elem) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as the final element is popped so done follows the last transfer directly.
        if (!inflight_q && (fifo_count == 2'd0 || (fifo_count == 2'd1 && fifo_pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      m_size_q   <= '0;
      n_size_q   <= '0;
      m_cnt_q    <= '0;
      n_cnt_q    <= '0;
      addr_q     <= '0;
      lane_q     <= '0;
      last_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_size_q   <= m_size_d;
      n_size_q   <= n_size_d;
      m_cnt_q    <= m_cnt_d;
      n_cnt_q    <= n_cnt_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
    end
  end

  assign sram_c_addr_o = issue ? issue_addr : addr_q;
  assign out_valid_o   = !fifo_empty;
  assign out_data_o    = fifo_empty ? '0 : fifo_rdata[OutDataWidth-1:0];
  assign out_last_o    = !fifo_empty && fifo_rdata[OutDataWidth];
  assign busy_o        = (state_q == StRun) || (state_q == StDrain);
  assign done_o        = (state_q == StDone);

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_c_result_reader.sv
// Directed bench for c_result_reader: packed SRAM C model, stream capture and scoreboard.
module tb_c_result_reader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [6:0]  m_size = '0;
  logic [6:0]  n_size = '0;
  logic [8:0]  addr;
  logic [63:0] rdata = '0;
  logic [31:0] out_data;
  logic        out_valid, out_last, busy, done;
  logic        out_ready = 1'b1;

  c_result_reader dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .M_size_i       (m_size),
    .N_size_i       (n_size),
    .sram_c_addr_o  (addr),
    .sram_c_rdata_i (rdata),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_last_o     (out_last),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [512];
  logic [31:0] cmat [32][32];
  always @(posedge clk) rdata <= mem[addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] q_data[$];
  bit          q_last[$];
  logic [31:0] exp_q[$];
  int          last_xfer_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  bit          valid_seen = 0;
  bit          stall_prev = 0;
  bit          watch_cnt = 0;
  logic [31:0] stall_data = '0;
  bit          rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", 64'(out_valid), 64'(1));
        check_eq("stall_data", 64'(out_data), 64'(stall_data));
      end
      if (out_valid) valid_seen = 1'b1;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (watch_cnt) check_eq("fifo_cnt_le2", 64'(dut.u_fifo.count_o <= 2'd2), 64'(1));
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic pulse_start(input int mi, input int ni);
    @(posedge clk);
    #1;
    m_size  = 7'(mi);
    n_size  = 7'(ni);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit toggle);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < max_cyc) begin
      @(posedge clk);
      #1;
      if (toggle) out_ready = rpat[$urandom_range(0, 3)];
      i++;
    end
    out_ready = 1'b1;
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic check_stream(input string tag);
    int nlast = 0;
    check_eq({tag, "_len"}, 64'(q_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < q_data.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), 64'(q_data[i]), 64'(exp_q[i]));
      if (q_last[i]) nlast++;
    end
    check_eq({tag, "_last_cnt"}, 64'(nlast), 64'(1));
    if (q_last.size() > 0) check_eq({tag, "_last_final"}, 64'(q_last[q_last.size()-1]), 64'(1));
  endtask

  task automatic clear_capture();
    q_data.delete();
    q_last.delete();
    valid_seen = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_last"}, 64'(out_last), 64'(0));
    check_eq({tag, "_data"}, 64'(out_data), 64'(0));
    check_eq({tag, "_addr"}, 64'(addr), 64'(0));
  endtask

  initial begin
    logic [31:0] exp1 [8];
    logic [8:0]  exp_addr [8];
    int          d0, w;
    exp1     = '{32'd100, 32'd102, 32'd101, 32'd103, 32'd104, 32'd106, 32'd105, 32'd107};
    exp_addr = '{9'd0, 9'd1, 9'd0, 9'd1, 9'd2, 9'd3, 9'd2, 9'd3};
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = {32'(101 + 2 * i), 32'(100 + 2 * i)};

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_ni = 1'b1;

    // 4x2 basic stream with address order
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(exp1[i]);
    clear_capture();
    pulse_start(4, 2);
    check_eq("busy_after_start", 64'(busy), 64'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("addr%0d", i), 64'(addr), 64'(exp_addr[i]));
    end
    wait_done("t1", 40, 1'b0);
    check_stream("t1");
    check_eq("t1_done_after_last", 64'(done_cyc - last_xfer_cyc), 64'(1));
    @(negedge clk);
    check_eq("t1_idle_busy", 64'(busy), 64'(0));

    // Backpressure with a toggling ready
    clear_capture();
    watch_cnt = 1'b1;
    pulse_start(4, 2);
    wait_done("t2", 200, 1'b1);
    watch_cnt = 1'b0;
    check_stream("t2");

    // Start re-pulsed mid-run with other sizes is ignored
    clear_capture();
    d0 = done_cnt;
    pulse_start(4, 2);
    repeat (3) @(posedge clk);
    #1;
    m_size  = 7'd2;
    n_size  = 7'd2;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done("t3", 40, 1'b0);
    check_stream("t3");
    repeat (4) @(negedge clk);
    check_eq("t3_single_done", 64'(done_cnt - d0), 64'(1));

    // Zero-size run: quick done, no data, address untouched
    clear_capture();
    pulse_start(0, 16);
    wait_done("t4", 4, 1'b0);
    check_eq("t4_done_lat_le2", 64'((done_cyc - start_cyc) <= 2), 64'(1));
    check_eq("t4_no_valid", 64'(valid_seen), 64'(0));
    check_eq("t4_addr_held", 64'(addr), 64'(3));

    // 32x32 random fill
    exp_q.delete();
    for (int m = 0; m < 32; m++) begin
      for (int n = 0; n < 32; n++) begin
        cmat[m][n] = $urandom;
        w = (m / 2) * 32 + n;
        mem[w][(m % 2) * 32 +: 32] = cmat[m][n];
        exp_q.push_back(cmat[m][n]);
      end
    end
    clear_capture();
    pulse_start(32, 32);
    wait_done("t5", 1200, 1'b0);
    check_stream("t5");
    check_eq("t5_cycles_le_1028", 64'((done_cyc - start_cyc) <= 1028), 64'(1));

    // Reset after 10 transfers, then a full rerun
    clear_capture();
    pulse_start(32, 32);
    for (int i = 0; i < 100 && q_data.size() < 10; i++) @(negedge clk);
    check_eq("t6_reached_10", 64'(q_data.size() >= 10), 64'(1));
    d0 = done_cnt;
    #1;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    check_eq("t6_no_done", 64'(done_cnt - d0), 64'(0));
    clear_capture();
    pulse_start(32, 32);
    wait_done("t6", 1200, 1'b0);
    check_stream("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
